ps2_rx_fifo_checked: RTL
========================

// Module: ps2_rx_fifo_checked
// PURPOSE
//  Parametrised PS/2 device-to-host receiver with a glitch filter, odd-parity and stop-bit checking,
//  a frame timeout and a show-ahead receive FIFO. Sits between the PS/2 pins and the keyboard
//  scan-code decoder, so the consumer can drain bytes at its own pace and see bad frames.
// PARAMETERS
//  FILTER_LEN      8     ps2c filter depth in clk cycles (>=2)
//  FIFO_AW         3     log2 of FIFO depth (depth = 2**FIFO_AW)
//  TIMEOUT_CYCLES  5000  clk cycles with no filtered falling edge before a frame in progress is aborted
// PORTS
//  clk             in   1  system clock; one clock domain
//  reset           in   1  synchronous, active-high reset
//  ps2c            in   1  raw PS/2 clock pin
//  ps2d            in   1  raw PS/2 data pin
//  rx_en           in   1  enables the start of a new frame; a frame already in progress always completes
//  rd_en           in   1  pop the FIFO head; ignored when empty
//  dout            out  8  FIFO head, show-ahead; 8'h00 when empty
//  empty           out  1  FIFO empty
//  full            out  1  FIFO full
//  busy            out  1  a frame is in progress (state != IDLE)
//  parity_err_tick out  1  one-cycle pulse: frame dropped, odd parity failed
//  frame_err_tick  out  1  one-cycle pulse: frame dropped, stop bit=0 or timeout
//  overflow_tick   out  1  one-cycle pulse: good frame dropped, FIFO full
// BEHAVIOUR
//  Reset (sync): filter=0, f_ps2c=0, IDLE, counters/pointers=0, empty=1, full=0, dout=0,
//   busy=0, all ticks=0. Applying reset mid-frame discards the partial frame and empties the FIFO.
//  Filter: FILTER_LEN-bit shift register of ps2c.
//   - f_ps2c goes to 1 when the register holds all ones, to 0 when it holds all zeros, else holds.
//   - fall_edge = f_ps2c_reg & ~f_ps2c_next. A pulse shorter than FILTER_LEN cycles produces no edge.
//   - ps2d is synchronised by two flops before it is sampled.
//  FSM states: IDLE, DATA, CHECK.
//   - IDLE: on fall_edge & rx_en: if ps2d==0 (start bit), n=9, clear the timer, go to DATA.
//     If ps2d==1, ignore the edge and stay in IDLE.
//   - DATA: on each fall_edge shift ps2d into sh[9:0], LSB first; timer=0.
//     If n==0, go to CHECK; else n=n-1. Ten shifts in total: 8 data, parity, stop.
//   - DATA timeout: the timer increments every cycle without an edge. At TIMEOUT_CYCLES-1 go to
//     IDLE and pulse frame_err_tick; nothing is pushed.
//   - CHECK (exactly 1 cycle, then IDLE): error priority is frame over parity over overflow;
//     only one tick fires per frame.
//     stop==0 -> frame_err_tick; else ^{data,parity}==0 -> parity_err_tick;
//     else if full & ~rd_en -> overflow_tick, byte dropped; else push data.
//  FIFO: synchronous, show-ahead, count width FIFO_AW+1, pointers wrap modulo depth.
//   - Push and pop in the same cycle: both happen, count unchanged, including when full.
//   - rd_en while empty: no effect. Stored data is never overwritten.
//  Latency: stop-bit fall_edge detected in cycle N -> CHECK in N+1 -> empty=0 and dout valid in N+2.
//  Deasserting rx_en mid-frame has no effect on that frame.
// STRUCTURE
//  Package ps2_pkg: state enum {IDLE, DATA, CHECK}; PS2_FRAME_BITS=11; function odd_parity_ok(data,p).
//  Sub-module ps2_sync_fifo #(W=8, AW=FIFO_AW): show-ahead FIFO with push, pop, empty, full.
//  Filter, edge detector, timer and FSM are inline in this module.
// TESTING
//  1 Frame 0x1C, parity=0, stop=1 -> empty falls 2 cycles after the last edge; dout=0x1C; no ticks.
//  2 0x1C with parity=1 -> single parity_err_tick; empty stays 1; busy falls after CHECK.
//  3 0x5A with stop=0 -> single frame_err_tick; FIFO unchanged.
//  4 Push 8 bytes (FIFO_AW=3) to reach full, then 0xAA -> overflow_tick; head still byte 0.
//    Repeat 0xAA with rd_en high in its CHECK cycle -> 0xAA accepted; full stays 1.
//  5 Stop ps2c after 4 data bits for TIMEOUT_CYCLES -> frame_err_tick; then IDLE.
//    Next frame 0xF0 (parity=1) -> dout=0xF0.
//  6 ps2c low glitch of FILTER_LEN-2 cycles in IDLE -> busy stays 0.
//    Assert reset mid-frame -> empty=1, busy=0; next frame 0x29 is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t DATA  = 2'd1;
    localparam state_t CHECK = 2'd2;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
        return ^{data, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_checked_if.sv
// Pin-side and consumer-side signals of the PS/2 receiver, bundled for the top-level port.
interface ps2_rx_fifo_checked_if;

    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       busy;
    logic       parity_err_tick;
    logic       frame_err_tick;
    logic       overflow_tick;

    modport master (
        output ps2c, ps2d, rx_en, rd_en,
        input  dout, empty, full, busy, parity_err_tick, frame_err_tick, overflow_tick
    );

    modport slave (
        input  ps2c, ps2d, rx_en, rd_en,
        output dout, empty, full, busy, parity_err_tick, frame_err_tick, overflow_tick
    );

endinterface

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO; push while full is accepted only together with a pop.
module ps2_sync_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo_checked.sv
// PS/2 device-to-host receiver: glitch-filtered clock, frame FSM with parity/stop/timeout
// checks, and a show-ahead FIFO towards the scan-code decoder.
module ps2_rx_fifo_checked
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input logic                  clk,
    input logic                  reset,
    ps2_rx_fifo_checked_if.slave bus
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [FILTER_LEN-1:0] filter_q;
    logic                  f_ps2c_q, f_ps2c_d, fall_edge;
    logic [1:0]            d_sync_q;

    state_t        state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [9:0]    sh_q, sh_d;
    logic [TW-1:0] timer_q, timer_d;

    logic       push;
    logic       parity_err, frame_err, overflow;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    // Filtered clock only changes once the whole window agrees.
    always_comb begin
        f_ps2c_d = f_ps2c_q;
        if (&filter_q)       f_ps2c_d = 1'b1;
        else if (~|filter_q) f_ps2c_d = 1'b0;
    end

    assign fall_edge = f_ps2c_q & ~f_ps2c_d;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        sh_d       = sh_q;
        timer_d    = timer_q;
        push       = 1'b0;
        parity_err = 1'b0;
        frame_err  = 1'b0;
        overflow   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_edge && bus.rx_en && !d_sync_q[1]) begin
                    state_d = DATA;
                    n_d     = 4'd9;
                    timer_d = '0;
                end
            end
            DATA: begin
                if (fall_edge) begin
                    sh_d    = {d_sync_q[1], sh_q[9:1]};
                    timer_d = '0;
                    if (n_q == 4'd0) state_d = CHECK;
                    else             n_d     = n_q - 4'd1;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    frame_err = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                // sh_q = {stop, parity, data[7:0]}; errors are mutually exclusive.
                state_d = IDLE;
                if (!sh_q[9])                             frame_err  = 1'b1;
                else if (!odd_parity_ok(sh_q[7:0], sh_q[8])) parity_err = 1'b1;
                else if (fifo_full && !bus.rd_en)         overflow   = 1'b1;
                else                                      push       = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filter_q <= '0;
            f_ps2c_q <= 1'b0;
            d_sync_q <= '0;
            state_q  <= IDLE;
            n_q      <= '0;
            sh_q     <= '0;
            timer_q  <= '0;
        end else begin
            filter_q <= {filter_q[FILTER_LEN-2:0], bus.ps2c};
            f_ps2c_q <= f_ps2c_d;
            d_sync_q <= {d_sync_q[0], bus.ps2d};
            state_q  <= state_d;
            n_q      <= n_d;
            sh_q     <= sh_d;
            timer_q  <= timer_d;
        end
    end

    ps2_sync_fifo #(
        .W  (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus.rd_en),
        .din   (sh_q[7:0]),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.dout            = fifo_dout;
    assign bus.empty           = fifo_empty;
    assign bus.full            = fifo_full;
    assign bus.busy            = (state_q != IDLE);
    assign bus.parity_err_tick = parity_err;
    assign bus.frame_err_tick  = frame_err;
    assign bus.overflow_tick   = overflow;

endmodule
